// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the control unit and the iterative
// multiplier/divider. Owns HI/LO, handles mthi/mtlo and div-by-zero.
// Optional watchdog: define MULDIV_TIMEOUT_EN to bound the RUN state
// to TIMEOUT cycles; otherwise timeout is tied low and no counter exists.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_init,
  output logic             mult_clr,
  input  logic             mult_stop,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_init,
  output logic             div_clr,
  input  logic             div_stop,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state;
  logic             sel_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Both units see the latched operands; only the selected one is sequenced.
  assign mult_a = a_q;
  assign mult_b = b_q;
  assign div_a  = a_q;
  assign div_b  = b_q;

  // Stop flag of the selected unit; the other unit's sticky stop is ignored.
  logic             stop_sel;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  assign stop_sel = sel_q ? div_stop : mult_stop;
  assign res_hi   = sel_q ? div_hi   : mult_hi;
  assign res_lo   = sel_q ? div_lo   : mult_lo;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt;
  logic          run_expired;
  assign run_expired = (run_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main sequencer: all outputs registered, pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      mult_init <= 1'b0;
      mult_clr  <= 1'b0;
      div_init  <= 1'b0;
      div_clr   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout   <= 1'b0;
      run_cnt   <= '0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      mult_clr <= 1'b0;
      div_clr  <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // mthi/mtlo commit first; a same-cycle op overwrites later.
          if (hilo_we) begin
            if (hilo_sel) hi_out <= hilo_wdata;
            else          lo_out <= hilo_wdata;
          end
          if (op_start) begin
            sel_q <= op_sel;
            a_q   <= op_a;
            b_q   <= op_b;
            busy  <= 1'b1;
            if (op_sel && (op_b == '0)) begin
              // Divide by zero: finish immediately, units untouched.
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              // Stop flags are sticky, so the unit must be cleared first.
              state <= CLEAR;
              if (op_sel) div_clr  <= 1'b1;
              else        mult_clr <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state <= RUN;
          if (sel_q) div_init  <= 1'b1;
          else       mult_init <= 1'b1;
`ifdef MULDIV_TIMEOUT_EN
          run_cnt <= '0;
`endif
        end
        RUN: begin
          if (stop_sel) begin
            hi_out    <= res_hi;
            lo_out    <= res_lo;
            mult_init <= 1'b0;
            div_init  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (run_expired) begin
            // Abandon the unit: drop init, clear it, leave HI/LO alone.
            mult_init <= 1'b0;
            div_init  <= 1'b0;
            if (sel_q) div_clr  <= 1'b1;
            else       mult_clr <= 1'b1;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with behavioural multiplier/divider stubs
// and a queue of expected completions checked when done pulses.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start, op_sel, hilo_we, hilo_sel;
  logic [31:0] op_a, op_b, hilo_wdata;
  logic        busy, done, div_zero, timeout;
  logic [31:0] hi_out, lo_out, mult_a, mult_b, div_a, div_b;
  logic        mult_init, mult_clr, mult_stop, div_init, div_clr, div_stop;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
    .hilo_wdata(hilo_wdata), .busy(busy), .done(done), .div_zero(div_zero),
    .timeout(timeout), .hi_out(hi_out), .lo_out(lo_out),
    .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init),
    .mult_clr(mult_clr), .mult_stop(mult_stop), .mult_hi(mult_hi),
    .mult_lo(mult_lo), .div_a(div_a), .div_b(div_b), .div_init(div_init),
    .div_clr(div_clr), .div_stop(div_stop), .div_hi(div_hi), .div_lo(div_lo)
  );

  // Unit stubs: stop rises after lat init cycles, sticky until clr/reset.
  int m_lat = 33, d_lat = 10, m_cnt, d_cnt;
  logic signed [63:0] prod;
  assign prod = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});

  always @(posedge clk) begin
    if (reset || mult_clr) begin
      m_cnt <= 0; mult_stop <= 1'b0; mult_hi <= '0; mult_lo <= '0;
    end else if (mult_init && !mult_stop) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == m_lat - 1) begin
        mult_stop <= 1'b1;
        mult_hi   <= prod[63:32];
        mult_lo   <= prod[31:0];
      end
    end
  end

  always @(posedge clk) begin
    if (reset || div_clr) begin
      d_cnt <= 0; div_stop <= 1'b0; div_hi <= '0; div_lo <= '0;
    end else if (div_init && !div_stop) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == d_lat - 1) begin
        div_stop <= 1'b1;
        div_hi   <= (div_b != 0) ? div_a % div_b : 32'd0;
        div_lo   <= (div_b != 0) ? div_a / div_b : 32'd0;
      end
    end
  end

  // Pulse/level counters sampled mid-cycle.
  int done_cnt, mclr_cnt, dclr_cnt, minit_cnt, dinit_cnt;
  always @(negedge clk) begin
    if (!reset) begin
      done_cnt  += int'(done);
      mclr_cnt  += int'(mult_clr);
      dclr_cnt  += int'(div_clr);
      minit_cnt += int'(mult_init);
      dinit_cnt += int'(div_init);
    end
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        to;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  // Drive op_start in the current cycle (cycle 0); returns in cycle 1.
  task automatic begin_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
    cyc = 0;
    op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
    tick();
    op_start = 1'b0;
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic finish_op(input string tag, input int budget);
    exp_t e;
    while (!done && cyc < budget) tick();
    e = sb.pop_front();
    if (!done) begin
      tests++; fails++;
      $error("FAIL %s_nodone: observed no done expected done by cycle %0d", tag, e.cyc);
    end else begin
      chk({tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
      chk({tag, "_hi"}, hi_out, e.hi);
      chk({tag, "_lo"}, lo_out, e.lo);
      chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
      chk({tag, "_to"}, {31'd0, timeout}, {31'd0, e.to});
      tick();
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    end
  endtask

  int d0, mc0, dc0, mi0, di0;

  initial begin
    reset = 1'b1; op_start = 0; op_sel = 0; op_a = 0; op_b = 0;
    hilo_we = 0; hilo_sel = 0; hilo_wdata = 0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_ctl", {26'd0, mult_init, mult_clr, div_init, div_clr, div_zero, timeout}, 32'd0);
    chk("rst_opa", mult_a, 32'd0);
    reset = 1'b0;
    tick();

    // Signed mult 7 * -3, 33 init cycles.
    m_lat = 33;
    mc0 = mclr_cnt; mi0 = minit_cnt; d0 = done_cnt;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 36});
    begin_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("m1_clr_c1", {31'd0, mult_clr}, 32'd1);
    chk("m1_busy", {31'd0, busy}, 32'd1);
    chk("m1_opa", mult_a, 32'd7);
    finish_op("m1", 200);
    chk("m1_clr_cnt", 32'(mclr_cnt - mc0), 32'd1);
    chk("m1_init_cnt", 32'(minit_cnt - mi0), 32'd34);
    chk("m1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Div 100 / 7, 10 init cycles; multiplier must stay idle.
    d_lat = 10;
    mi0 = minit_cnt; di0 = dinit_cnt;
    sb.push_back('{32'd2, 32'd14, 1'b0, 1'b0, 13});
    begin_op(1'b1, 32'd100, 32'd7);
    chk("d1_clr_c1", {31'd0, div_clr}, 32'd1);
    finish_op("d1", 200);
    chk("d1_minit", 32'(minit_cnt - mi0), 32'd0);
    chk("d1_dinit", 32'(dinit_cnt - di0), 32'd11);

    // mthi/mtlo preload, then divide by zero.
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h55; tick();
    hilo_sel = 1'b0; hilo_wdata = 32'hAA; tick();
    hilo_we = 1'b0;
    chk("mthi", hi_out, 32'h55);
    chk("mtlo", lo_out, 32'hAA);
    mc0 = mclr_cnt; dc0 = dclr_cnt; mi0 = minit_cnt; di0 = dinit_cnt;
    sb.push_back('{32'h55, 32'hAA, 1'b1, 1'b0, 1});
    begin_op(1'b1, 32'd5, 32'd0);
    finish_op("dz", 20);
    chk("dz_untouched", 32'((mclr_cnt - mc0) + (dclr_cnt - dc0) + (minit_cnt - mi0) + (dinit_cnt - di0)), 32'd0);

    // Mult 2*2; op_start and mthi during RUN are dropped. div_stop is
    // still sticky from the earlier div and must be ignored.
    sb.push_back('{32'd0, 32'd4, 1'b0, 1'b0, 36});
    begin_op(1'b0, 32'd2, 32'd2);
    while (cyc < 5) tick();
    op_start = 1'b1; op_a = 32'd3; op_b = 32'd4;
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
    tick();
    op_start = 1'b0; hilo_we = 1'b0;
    chk("busy_opa_kept", mult_a, 32'd2);
    chk("busy_mthi_drop", hi_out, 32'h55);
    finish_op("m2", 200);

    // Same-cycle mtlo and op_start: write lands, result overwrites.
    m_lat = 5;
    sb.push_back('{32'd0, 32'd30, 1'b0, 1'b0, 8});
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h99;
    begin_op(1'b0, 32'd5, 32'd6);
    hilo_we = 1'b0;
    chk("same_cyc_mtlo", lo_out, 32'h99);
    finish_op("m3", 50);

    // Reset in the middle of a running div.
    d_lat = 20;
    begin_op(1'b1, 32'd50, 32'd3);
    while (cyc < 10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi_out, 32'd0);
    chk("mrst_lo", lo_out, 32'd0);
    chk("mrst_dinit", {31'd0, div_init}, 32'd0);
    d0 = done_cnt;
    repeat (30) tick();
    chk("mrst_nodone", 32'(done_cnt - d0), 32'd0);

    // Stop never arrives.
    m_lat = 100000;
    mc0 = mclr_cnt; d0 = done_cnt;
`ifdef MULDIV_TIMEOUT_EN
    sb.push_back('{32'd0, 32'd0, 1'b0, 1'b1, 66});
    begin_op(1'b0, 32'd9, 32'd9);
    finish_op("wdog", 200);
    chk("wdog_clr_cnt", 32'(mclr_cnt - mc0), 32'd2);
    chk("wdog_idle", {31'd0, busy}, 32'd0);
`else
    begin_op(1'b0, 32'd9, 32'd9);
    while (cyc < 100) tick();
    chk("hang_busy", {31'd0, busy}, 32'd1);
    chk("hang_to", {31'd0, timeout}, 32'd0);
    chk("hang_nodone", 32'(done_cnt - d0), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    chk("hang_rst_idle", {31'd0, busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer between the multicycle control unit and the iterative 32-bit multiplier and divider units.
- Owns the architectural HI/LO registers.
- Accepts one mult or div request at a time, runs the selected unit through its clear/init/stop handshake, commits the result to HI/LO and signals completion so the control unit can leave its stall state.
- Also services mthi/mtlo writes and div-by-zero detection.

Parameters:
WIDTH, 32, operand and HI/LO width
TIMEOUT, 64, RUN-state cycle limit, used only when the watchdog feature is compiled in

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
op_start  in  1  request pulse, sampled in IDLE only
op_sel  in  1  0 = mult, 1 = div
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt)
hilo_we  in  1  mthi/mtlo write enable
hilo_sel  in  1  0 = write LO, 1 = write HI
hilo_wdata  in  WIDTH  mthi/mtlo data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle pulse, concurrent with done, on div with op_b == 0
timeout  out  1  one-cycle watchdog pulse, concurrent with done
hi_out  out  WIDTH  HI register
lo_out  out  WIDTH  LO register
mult_a, mult_b  out  WIDTH  multiplier operands
mult_init  out  1  held high while the multiplier runs
mult_clr  out  1  one-cycle clear to the multiplier
mult_stop  in  1  multiplier finished (sticky until cleared)
mult_hi, mult_lo  in  WIDTH  multiplier result
div_a, div_b  out  WIDTH  divider operands
div_init, div_clr  out  1  same meaning as the multiplier pair
div_stop  in  1  divider finished (sticky until cleared)
div_hi, div_lo  in  WIDTH  remainder, quotient

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. All outputs registered.
- Reset values: state IDLE; hi_out/lo_out = 0; operand regs = 0; busy, done, div_zero, timeout, *_init, *_clr = 0.
- Reset mid-operation: return to IDLE next edge, HI/LO cleared. No clear pulse is issued; the units share reset.
- IDLE:
  - If op_start: latch op_sel, op_a, op_b into internal regs.
  - div with op_b == 0: go to DONE with div_zero pending; no unit is touched.
  - Otherwise: go to CLEAR.
- Operand latching: mult_a/b and div_a/b show the latched operands from CLEAR until the next accepted op_start. Both units see the same values; only the selected unit is sequenced.
- CLEAR: selected *_clr = 1 for exactly one cycle, *_init = 0. Go to RUN.
  - The clear is required because the unit stop flags are sticky.
- RUN:
  - Selected *_init = 1.
  - On the first cycle the selected *_stop is sampled high: load hi_out <= unit hi and lo_out <= unit lo, drop *_init on the next edge, go to DONE.
  - The unselected unit's stop is ignored.
- DONE: done = 1 for one cycle (div_zero/timeout too if pending), busy = 1. Go to IDLE.
- Latency: op_start at cycle 0, CLEAR at cycle 1, RUN from cycle 2. If stop is first seen at cycle k, HI/LO update at the end of cycle k and done is high at cycle k+1. A new op_start is accepted at cycle k+2.
  - Div-by-zero: done at cycle 1.
- Request rules:
  - op_start while busy is ignored and not queued.
  - hilo_we is honoured only in IDLE; ignored while busy.
  - Same IDLE cycle with op_start and hilo_we: the write commits, then the op starts; the op result later overwrites.
- Div by zero: HI/LO unchanged.

Optional Feature:
MULDIV_TIMEOUT_EN
- Defined: a cycle counter runs in RUN. If it reaches TIMEOUT without stop:
  - selected *_init drops;
  - a one-cycle *_clr is issued;
  - state goes to DONE with timeout pending;
  - HI/LO are unchanged.
- Undefined: RUN waits indefinitely, timeout is tied to 0 and no counter is synthesised.
- The port is present in both builds.

Test Plan:
- mult, op_a = 7, op_b = 0xFFFFFFFD, stub stop after 33 init cycles -> hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB, done exactly 1 cycle, mult_clr one pulse at cycle 1.
- div, op_a = 100, op_b = 7 -> lo_out = 14, hi_out = 2, div_init high, mult_init never high.
- div, op_b = 0 with HI = 0x55, LO = 0xAA preloaded by mthi/mtlo -> done and div_zero at cycle 1, HI/LO unchanged, no clr/init pulse.
- Second op_start (mult 3*4) at cycle 5 of a running mult 2*2 -> ignored, result lo = 4; mthi write 0x1234 issued during RUN is dropped.
- reset asserted at cycle 10 of a running div -> next cycle busy = 0, hi_out = lo_out = 0, div_init = 0, no done pulse.
- With MULDIV_TIMEOUT_EN and TIMEOUT = 64, stub stop stuck low -> done and timeout at RUN cycle 64 + 1, one clr pulse, HI/LO unchanged. Without the macro, busy stays high.
